// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one block memory port between I-cache and D-cache
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              ic_read,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_ready,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {S_IDLE, S_IC, S_DC, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               last_dc_q, last_dc_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]  ic_rdata_q, ic_rdata_d;
    logic [DATA_W-1:0]  dc_rdata_q, dc_rdata_d;
    logic               ic_ready_q, ic_ready_d;
    logic               dc_ready_q, dc_ready_d;
    logic               dc_pend, grant_dc;

    assign dc_pend  = dc_read | dc_write;
    // On a tie the D-cache wins unless it was the last client served.
    assign grant_dc = dc_pend && (!ic_read || !last_dc_q);

    always_comb begin
        state_d     = state_q;
        last_dc_d   = last_dc_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ic_rdata_d  = ic_rdata_q;
        dc_rdata_d  = dc_rdata_q;
        ic_ready_d  = 1'b0;
        dc_ready_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_dc) begin
                    state_d    = S_DC;
                    mem_addr_d = dc_addr;
                    if (dc_write) begin
                        mem_write_d = 1'b1;
                        mem_wdata_d = dc_wdata;
                    end else begin
                        mem_read_d = 1'b1;
                    end
                end else if (ic_read) begin
                    state_d    = S_IC;
                    mem_addr_d = ic_addr;
                    mem_read_d = 1'b1;
                end
            end
            S_IC: begin
                if (mem_ready) begin
                    state_d    = S_DONE;
                    mem_read_d = 1'b0;
                    ic_rdata_d = mem_rdata;
                    ic_ready_d = 1'b1;
                    last_dc_d  = 1'b0;
                end
            end
            S_DC: begin
                if (mem_ready) begin
                    state_d     = S_DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (mem_read_q) begin
                        dc_rdata_d = mem_rdata;
                    end
                    dc_ready_d = 1'b1;
                    last_dc_d  = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q     <= S_IDLE;
            last_dc_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
            ic_ready_q  <= 1'b0;
            dc_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_dc_q   <= last_dc_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ic_rdata_q  <= ic_rdata_d;
            dc_rdata_q  <= dc_rdata_d;
            ic_ready_q  <= ic_ready_d;
            dc_ready_q  <= dc_ready_d;
        end
    end

    assign ic_rdata  = ic_rdata_q;
    assign ic_ready  = ic_ready_q;
    assign dc_rdata  = dc_rdata_q;
    assign dc_ready  = dc_ready_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a latency-programmable memory model
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          proc_reset = 1'b1;
    logic          ic_read = 1'b0;
    logic [AW-1:0] ic_addr = '0;
    logic [DW-1:0] ic_rdata;
    logic          ic_ready;
    logic          dc_read = 1'b0;
    logic          dc_write = 1'b0;
    logic [AW-1:0] dc_addr = '0;
    logic [DW-1:0] dc_wdata = '0;
    logic [DW-1:0] dc_rdata;
    logic          dc_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .ic_read(ic_read), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
        .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_ready(dc_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_dc;
        logic [DW-1:0] data;
    } sb_t;

    sb_t           sb[$];
    logic [DW-1:0] mem_model [logic [AW-1:0]];
    int            tests_run = 0;
    int            tests_failed = 0;
    int            mem_lat = 1;
    bit            mem_auto = 1'b1;
    bit            force_ready = 1'b0;
    int            wait_cnt = 0;
    int            txn_cnt = 0;
    int            ready_cnt = 0;
    bit            strobe_prev = 1'b0;
    bit            excl_err = 1'b0;
    logic [DW-1:0] exp_ic_rdata = '0;
    logic [DW-1:0] exp_dc_rdata = '0;

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {4{16'hC0DE, a[15:0]}};
    endfunction

    // Memory responder: raises mem_ready mem_lat cycles after seeing a strobe.
    always @(negedge clk) begin
        if (mem_ready) begin
            mem_ready = 1'b0;
        end else if (force_ready) begin
            mem_ready = 1'b1;
            mem_rdata = {4{32'hDEADBEEF}};
        end else if (mem_auto && (mem_read || mem_write)) begin
            if (wait_cnt >= mem_lat - 1) begin
                mem_ready = 1'b1;
                wait_cnt  = 0;
                if (mem_write) mem_model[mem_addr] = mem_wdata;
                else mem_rdata = model_rd(mem_addr);
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (ic_ready && dc_ready) excl_err = 1'b1;
        if (mem_read && mem_write) excl_err = 1'b1;
        if ((mem_read || mem_write) && !strobe_prev) txn_cnt++;
        if (ic_ready || dc_ready) ready_cnt++;
        strobe_prev = mem_read || mem_write;
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({mem_read, mem_write, mem_addr, mem_wdata, ic_rdata, dc_rdata, ic_ready, dc_ready} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: some output nonzero (mem_read=%0b mem_write=%0b mem_addr=%h ic_ready=%0b dc_ready=%0b), required all 0",
                     mem_read, mem_write, mem_addr, ic_ready, dc_ready);
        end
        proc_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ic_read();
        sb_t e;
        bit  seen = 0;
        int  hold_bad = 0;
        int  t0;
        mem_lat = 3;
        mem_model[28'h10] = {4{32'hA5A5A5A5}};
        t0 = txn_cnt;
        ic_read = 1'b1;
        ic_addr = 28'h10;
        sb.push_back('{is_dc: 1'b0, data: {4{32'hA5A5A5A5}}});
        @(negedge clk);
        ic_addr = 28'h7777;
        tests_run++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h10) begin
            tests_failed++;
            $display("FAIL ic_grant: mem_read=%0b mem_addr=%h, required 1 and 0000010", mem_read, mem_addr);
        end
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (ic_ready || dc_ready) seen = 1;
            else if (mem_addr !== 28'h10 || mem_read !== 1'b1) hold_bad++;
        end
        tests_run++;
        if (!seen || hold_bad != 0) begin
            tests_failed++;
            $display("FAIL ic_hold: ready_seen=%0b hold_errors=%0d, required 1 and 0", seen, hold_bad);
        end
        e = sb.pop_front();
        tests_run++;
        if ({ic_ready, dc_ready} !== {!e.is_dc, e.is_dc} || ic_rdata !== e.data) begin
            tests_failed++;
            $display("FAIL ic_complete: ic_ready=%0b dc_ready=%0b ic_rdata=%h, required %0b %0b %h",
                     ic_ready, dc_ready, ic_rdata, !e.is_dc, e.is_dc, e.data);
        end
        exp_ic_rdata = e.data;
        @(posedge clk);
        #1 ic_read = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ic_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ic_pulse_width: ic_ready=%0b, required 0", ic_ready);
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (txn_cnt - t0 != 1 || mem_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL ic_no_duplicate: transactions=%0d mem_read=%0b, required 1 and 0", txn_cnt - t0, mem_read);
        end
    endtask

    task automatic test_dc_write();
        sb_t e;
        mem_lat = 1;
        dc_write = 1'b1;
        dc_addr  = 28'h20;
        dc_wdata = 128'h1234;
        sb.push_back('{is_dc: 1'b1, data: exp_dc_rdata});
        @(negedge clk);
        dc_wdata = '1;
        tests_run++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== 128'h1234 || mem_addr !== 28'h20) begin
            tests_failed++;
            $display("FAIL dc_write_strobe: mem_write=%0b mem_read=%0b mem_wdata=%h mem_addr=%h, required 1 0 1234 0000020",
                     mem_write, mem_read, mem_wdata, mem_addr);
        end
        @(negedge clk);
        e = sb.pop_front();
        tests_run++;
        if ({ic_ready, dc_ready} !== {!e.is_dc, e.is_dc} || dc_rdata !== e.data) begin
            tests_failed++;
            $display("FAIL dc_write_complete: ic_ready=%0b dc_ready=%0b dc_rdata=%h, required 0 1 %h",
                     ic_ready, dc_ready, dc_rdata, e.data);
        end
        @(posedge clk);
        #1 dc_write = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (mem_model[28'h20] !== 128'h1234 || mem_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL dc_write_data: memory=%h mem_write=%0b, required 1234 and 0", mem_model[28'h20], mem_write);
        end
    endtask

    task automatic test_tie(input logic [AW-1:0] ia, input logic [AW-1:0] da, input string tag);
        sb_t e;
        int  done = 0;
        mem_lat = 1;
        ic_read = 1'b1;
        ic_addr = ia;
        dc_read = 1'b1;
        dc_addr = da;
        sb.push_back('{is_dc: 1'b1, data: model_rd(da)});
        sb.push_back('{is_dc: 1'b0, data: model_rd(ia)});
        for (int i = 0; i < 60 && done < 2; i++) begin
            @(negedge clk);
            if (ic_ready || dc_ready) begin
                done++;
                e = sb.pop_front();
                tests_run++;
                if ({ic_ready, dc_ready} !== {!e.is_dc, e.is_dc} ||
                    (e.is_dc ? dc_rdata : ic_rdata) !== e.data) begin
                    tests_failed++;
                    $display("FAIL %s_order%0d: ic_ready=%0b dc_ready=%0b ic_rdata=%h dc_rdata=%h, required dc=%0b data=%h",
                             tag, done, ic_ready, dc_ready, ic_rdata, dc_rdata, e.is_dc, e.data);
                end
                if (e.is_dc) exp_dc_rdata = e.data;
                else exp_ic_rdata = e.data;
                @(posedge clk);
                #1;
                if (e.is_dc) dc_read = 1'b0;
                else ic_read = 1'b0;
            end
        end
        tests_run++;
        if (done != 2) begin
            tests_failed++;
            $display("FAIL %s_timeout: completions=%0d, required 2", tag, done);
        end
        ic_read = 1'b0;
        dc_read = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rw_both();
        sb_t e;
        bit  seen = 0;
        bit  rd_seen = 0;
        int  t0 = txn_cnt;
        mem_lat = 2;
        dc_read  = 1'b1;
        dc_write = 1'b1;
        dc_addr  = 28'h40;
        dc_wdata = 128'hBEEF_0000_0000_CAFE;
        sb.push_back('{is_dc: 1'b1, data: exp_dc_rdata});
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (mem_read) rd_seen = 1;
            if (dc_ready || ic_ready) seen = 1;
        end
        e = sb.pop_front();
        tests_run++;
        if (!seen || dc_ready !== 1'b1 || dc_rdata !== e.data) begin
            tests_failed++;
            $display("FAIL rw_complete: seen=%0b dc_ready=%0b dc_rdata=%h, required 1 1 %h", seen, dc_ready, dc_rdata, e.data);
        end
        @(posedge clk);
        #1 begin dc_read = 1'b0; dc_write = 1'b0; end
        repeat (4) @(negedge clk);
        tests_run++;
        if (rd_seen || txn_cnt - t0 != 1 || mem_model[28'h40] !== 128'hBEEF_0000_0000_CAFE) begin
            tests_failed++;
            $display("FAIL rw_single_write: mem_read_seen=%0b transactions=%0d memory=%h, required 0 1 beef00000000cafe",
                     rd_seen, txn_cnt - t0, mem_model[28'h40]);
        end
    endtask

    task automatic test_reset_mid();
        int r0;
        mem_auto = 1'b0;
        ic_read = 1'b1;
        ic_addr = 28'h50;
        @(negedge clk);
        tests_run++;
        if (mem_read !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_grant: mem_read=%0b, required 1", mem_read);
        end
        #2 proc_reset = 1'b1;
        #1;
        tests_run++;
        if ({mem_read, mem_addr, ic_rdata, dc_rdata} !== '0) begin
            tests_failed++;
            $display("FAIL mid_async_reset: mem_read=%0b mem_addr=%h ic_rdata=%h dc_rdata=%h, required all 0",
                     mem_read, mem_addr, ic_rdata, dc_rdata);
        end
        ic_read = 1'b0;
        #1 proc_reset = 1'b0;
        r0 = ready_cnt;
        @(negedge clk);
        #1 force_ready = 1'b1;
        @(negedge clk);
        #1 force_ready = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (ready_cnt != r0 || {mem_read, mem_write, mem_addr, mem_wdata, ic_rdata, dc_rdata, ic_ready, dc_ready} !== '0) begin
            tests_failed++;
            $display("FAIL mid_stray_ready: ready_pulses=%0d mem_read=%0b ic_rdata=%h, required 0 pulses and all outputs 0",
                     ready_cnt - r0, mem_read, ic_rdata);
        end
        mem_auto = 1'b1;
        ic_read = 1'b1;
        ic_addr = 28'h60;
        repeat (4) @(negedge clk);
        tests_run++;
        if (ic_rdata !== model_rd(28'h60)) begin
            tests_failed++;
            $display("FAIL mid_recover: ic_rdata=%h, required %h", ic_rdata, model_rd(28'h60));
        end
        ic_read = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ic_read();
        test_dc_write();
        @(negedge clk) proc_reset = 1'b1;
        @(negedge clk) proc_reset = 1'b0;
        exp_ic_rdata = '0;
        exp_dc_rdata = '0;
        test_tie(28'h30, 28'h20, "tie1");
        test_tie(28'h31, 28'h32, "tie2");
        test_rw_both();
        test_reset_mid();
        tests_run++;
        if (excl_err) begin
            tests_failed++;
            $display("FAIL exclusivity: overlap_seen=%0b, required 0", excl_err);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
